// File: rtl/qnigma_pkg.sv
// qnigma_pkg: shared constants, types and header-byte helper for the ICMP echo-reply transmitter.
package qnigma_pkg;

   localparam logic [7:0]  ICMP_ECHO_REPLY_TYPE = 8'h00;
   localparam logic [7:0]  ICMP_ECHO_CODE       = 8'h00;
   localparam int unsigned ICMP_HDR_LEN         = 8;
   localparam int unsigned ECHO_FIELD_W         = 16;
   localparam int unsigned CKS_W                = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SUM   = 3'd1,
      S_FOLD1 = 3'd2,
      S_FOLD2 = 3'd3,
      S_HDR   = 3'd4,
      S_PLD   = 3'd5,
      S_DONE  = 3'd6,
      S_TOUT  = 3'd7
   } icmp_tx_fsm_t;

   // Fields captured from the upstream request
   typedef struct packed {
      logic [ECHO_FIELD_W-1:0] id;
      logic [ECHO_FIELD_W-1:0] seq;
      logic [ECHO_FIELD_W-1:0] len;
   } echo_req_t;

   // Byte idx of the 8-byte echo-reply header (type, code, checksum, id, seq)
   function automatic logic [7:0] echo_hdr_byte(input logic [2:0]              idx,
                                                input logic [ECHO_FIELD_W-1:0] c,
                                                input logic [ECHO_FIELD_W-1:0] id,
                                                input logic [ECHO_FIELD_W-1:0] seq);
      logic [7:0] b;
      b = 8'h00;
      case (idx)
         3'd0:    b = ICMP_ECHO_REPLY_TYPE;
         3'd1:    b = ICMP_ECHO_CODE;
         3'd2:    b = c[15:8];
         3'd3:    b = c[7:0];
         3'd4:    b = id[15:8];
         3'd5:    b = id[7:0];
         3'd6:    b = seq[15:8];
         default: b = seq[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/qnigma_cks_fold.sv
// qnigma_cks_fold: one end-around-carry fold step of a 32-bit ones-complement partial sum.
module qnigma_cks_fold
   import qnigma_pkg::*;
(
   input  logic [CKS_W-1:0] s,
   output logic [CKS_W-1:0] f
);

   localparam int unsigned HALF = CKS_W / 2;

   // Upper half added back into the lower half
   assign f = CKS_W'(s[CKS_W-1:HALF]) + CKS_W'(s[HALF-1:0]);

endmodule

// File: rtl/qnigma_icmp_echo_tx.sv
// qnigma_icmp_echo_tx: finishes the echo-reply checksum and serialises header + buffered payload.
// Optional FIFO-starvation abort enabled by defining QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN.
module qnigma_icmp_echo_tx
   import qnigma_pkg::*;
#(
   parameter int unsigned MAX_PLD = 1472
`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_TICKS = 1024
`endif
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [15:0] id,
   input  logic [15:0] seq,
   input  logic [15:0] len,
   input  logic [31:0] cks,
   input  logic [7:0]  fifo_dat,
   input  logic        fifo_empty,
   output logic        fifo_rd,
   input  logic        rdy,
   output logic        val,
   output logic [7:0]  dat,
   output logic        lst,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned IDX_W    = $clog2(ICMP_HDR_LEN);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ICMP_HDR_LEN - 1);

   icmp_tx_fsm_t              state, state_d;
   echo_req_t                 req_q, req_d;
   logic [CKS_W-1:0]          sum_q, sum_d, fold_s;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [ECHO_FIELD_W-1:0]   cnt_q, cnt_d;
   logic [ECHO_FIELD_W-1:0]   cks_c;
   logic                      busy_d, done_d, err_d;
   logic                      xfer_c;

`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
   localparam int unsigned STV_W = $clog2(TIMEOUT_TICKS + 1);
   logic [STV_W-1:0] stv_q, stv_d;
`endif

   qnigma_cks_fold u_fold (
      .s (sum_q),
      .f (fold_s)
   );

   assign cks_c  = ~sum_q[ECHO_FIELD_W-1:0];
   assign xfer_c = val & rdy;

   // Byte stream mux: header from captured fields, payload straight from the FWFT FIFO
   always_comb begin
      val     = 1'b0;
      dat     = 8'h00;
      lst     = 1'b0;
      fifo_rd = 1'b0;
      case (state)
         S_HDR: begin
            val = 1'b1;
            dat = echo_hdr_byte(idx_q, cks_c, req_q.id, req_q.seq);
            lst = (idx_q == IDX_LAST) && (req_q.len == '0);
         end
         S_PLD: begin
            val     = ~fifo_empty;
            dat     = fifo_dat;
            lst     = ~fifo_empty && (cnt_q == 16'd1);
            fifo_rd = ~fifo_empty & rdy;
         end
         S_TOUT: begin
            val = 1'b1;
            lst = 1'b1;
         end
         default: ;
      endcase
   end

   // Next-state, checksum datapath and status pulses
   always_comb begin
      state_d = state;
      req_d   = req_q;
      sum_d   = sum_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
      stv_d   = stv_q;
`endif
      case (state)
         S_IDLE: begin
            if (req) begin
               if (len > 16'(MAX_PLD)) begin
                  err_d = 1'b1;
               end else begin
                  req_d   = '{id: id, seq: seq, len: len};
                  sum_d   = cks;
                  idx_d   = '0;
                  cnt_d   = len;
                  state_d = S_SUM;
               end
            end
         end
         S_SUM: begin
            sum_d   = sum_q + CKS_W'({ICMP_ECHO_REPLY_TYPE, ICMP_ECHO_CODE})
                            + CKS_W'(req_q.id) + CKS_W'(req_q.seq);
            state_d = S_FOLD1;
         end
         S_FOLD1: begin
            sum_d   = fold_s;
            state_d = S_FOLD2;
         end
         S_FOLD2: begin
            sum_d   = fold_s;
            state_d = S_HDR;
`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
            stv_d   = '0;
`endif
         end
         S_HDR: begin
            if (xfer_c) begin
               if (idx_q == IDX_LAST) begin
                  state_d = (req_q.len == '0) ? S_DONE : S_PLD;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_PLD: begin
            if (xfer_c) begin
               cnt_d = cnt_q - 16'd1;
               if (cnt_q == 16'd1) begin
                  state_d = S_DONE;
               end
            end
`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
            if (xfer_c) begin
               stv_d = '0;
            end else if (fifo_empty) begin
               if (stv_q == STV_W'(TIMEOUT_TICKS - 1)) begin
                  stv_d   = '0;
                  state_d = S_TOUT;
               end else begin
                  stv_d = stv_q + STV_W'(1);
               end
            end
`endif
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
         S_TOUT: begin
            if (xfer_c) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   // State and capture registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
         req_q <= '0;
         sum_q <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         err   <= 1'b0;
`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
         stv_q <= '0;
`endif
      end else begin
         state <= state_d;
         req_q <= req_d;
         sum_q <= sum_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         busy  <= busy_d;
         done  <= done_d;
         err   <= err_d;
`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
         stv_q <= stv_d;
`endif
      end
   end

endmodule

// File: tb/tb_qnigma_icmp_echo_tx.sv
// tb_qnigma_icmp_echo_tx: bench for the ICMP echo-reply transmitter.
module tb_qnigma_icmp_echo_tx;

   localparam int unsigned MAX_PLD = 1472;
`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
   localparam int unsigned TO_TICKS = 16;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req, rdy, fifo_empty;
   logic [15:0] id, seq, len;
   logic [31:0] cks;
   logic [7:0]  fifo_dat;
   logic        fifo_rd, val, lst, busy, done, err;
   logic [7:0]  dat;

   always #5 clk = ~clk;

`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
   qnigma_icmp_echo_tx #(.MAX_PLD(MAX_PLD), .TIMEOUT_TICKS(TO_TICKS)) dut (
`else
   qnigma_icmp_echo_tx #(.MAX_PLD(MAX_PLD)) dut (
`endif
      .clk(clk), .rst(rst), .req(req), .id(id), .seq(seq), .len(len), .cks(cks),
      .fifo_dat(fifo_dat), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .rdy(rdy),
      .val(val), .dat(dat), .lst(lst), .busy(busy), .done(done), .err(err));

   int checks = 0;
   int errors = 0;
   int ncyc = 0;

   logic [7:0] fifo_q[$];
   logic [7:0] pl_q[$];
   logic [8:0] got[$];
   logic [8:0] exp_q[$];
   int         got_cyc[$];

   logic rd_pending, prev_stall, prev_lst, gate;
   logic [7:0] prev_dat;
   int n_rd, n_done, n_err, done_cyc, err_cyc, first_val_cyc, first_busy_cyc;
   int hold_bad, gap_bad, busy_done_bad, busy_seen, last_xfer_cyc, req_cyc;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_stats();
      got.delete(); got_cyc.delete(); fifo_q.delete();
      n_rd = 0; n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
      first_val_cyc = -1; first_busy_cyc = -1; hold_bad = 0; gap_bad = 0;
      busy_done_bad = 0; busy_seen = 0; last_xfer_cyc = -1;
   endtask

   // One clock: update FIFO/inputs on the falling edge, then observe the settled outputs
   task automatic cyc(input logic r, input logic rq, input logic g);
      @(negedge clk);
      if (rd_pending) begin
         if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         rd_pending = 1'b0;
      end
      rdy  = r;
      req  = rq;
      gate = g && !prev_stall;
      fifo_empty = gate || (fifo_q.size() == 0);
      fifo_dat   = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
      #1;
      ncyc++;
      if (prev_stall && (!val || dat != prev_dat || lst != prev_lst)) hold_bad++;
      if (fifo_empty && val && got.size() >= 8) gap_bad++;
      if (fifo_rd && (fifo_empty || !rdy)) gap_bad++;
      if (val && first_val_cyc < 0) first_val_cyc = ncyc;
      if (busy && first_busy_cyc < 0) first_busy_cyc = ncyc;
      if (busy) busy_seen++;
      if (val && rdy) begin
         got.push_back({lst, dat});
         got_cyc.push_back(ncyc);
         last_xfer_cyc = ncyc;
      end
      if (fifo_rd) begin n_rd++; rd_pending = 1'b1; end
      if (done) begin n_done++; done_cyc = ncyc; if (busy) busy_done_bad++; end
      if (err) begin n_err++; err_cyc = ncyc; end
      prev_stall = val && !rdy;
      prev_dat   = dat;
      prev_lst   = lst;
   endtask

   // Reference: ones-complement sum folded until it fits, then the reply byte stream
   task automatic build_exp(input logic [15:0] i_id, input logic [15:0] i_seq, input logic [31:0] i_cks);
      longint s;
      logic [15:0] c;
      logic [7:0] hb[8];
      s = longint'(i_cks) + longint'(i_id) + longint'(i_seq);
      while (s > 64'hFFFF) s = (s >> 16) + (s & 64'hFFFF);
      c = ~16'(s);
      hb = '{8'h00, 8'h00, c[15:8], c[7:0], i_id[15:8], i_id[7:0], i_seq[15:8], i_seq[7:0]};
      exp_q.delete();
      foreach (hb[k]) exp_q.push_back({1'b0, hb[k]});
      foreach (pl_q[k]) exp_q.push_back({1'b0, pl_q[k]});
      exp_q[exp_q.size()-1][8] = 1'b1;
   endtask

   task automatic issue_req(input logic [15:0] i_id, input logic [15:0] i_seq,
                            input logic [15:0] i_len, input logic [31:0] i_cks);
      id = i_id; seq = i_seq; len = i_len; cks = i_cks;
      cyc(1'b1, 1'b1, 1'b0);
      req_cyc = ncyc;
   endtask

   task automatic run_pkt(input string tag, input logic [15:0] i_id, input logic [15:0] i_seq,
                          input logic [15:0] i_len, input logic [31:0] i_cks, input int rmode,
                          input int gap_at, input int gap_len, input bit mid_req);
      int budget, k, gap_left, empties, bad, last_sz;
      logic r, g, mq;
      logic pat[4];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      clear_stats();
      fifo_q = pl_q;
      build_exp(i_id, i_seq, i_cks);
      issue_req(i_id, i_seq, i_len, i_cks);
      budget = 120 + 8 * int'(i_len);
      k = 0; gap_left = gap_len; empties = 0; last_sz = 0;
      while (n_done == 0 && n_err == 0 && k < budget) begin
         r = (rmode == 0) ? 1'b1 : (rmode == 1) ? pat[k % 4] : ($urandom_range(0, 3) != 0);
         if (got.size() != last_sz) begin empties = 0; last_sz = got.size(); end
         g = 1'b0;
         if (gap_left > 0 && got.size() == 8 + gap_at) begin
            g = 1'b1; gap_left--;
         end else if (rmode == 2 && empties < 8 && $urandom_range(0, 3) == 0) begin
            g = 1'b1; empties++;
         end
         mq = mid_req && (k == 3);
         if (mq) begin id = 16'hDEAD; len = 16'd2000; end
         cyc(r, mq, g);
         k++;
      end
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check({tag, " completes"}, longint'(k < budget), 1);
      check({tag, " byte count"}, got.size(), exp_q.size());
      bad = 0;
      foreach (exp_q[i]) if (i >= got.size() || got[i] !== exp_q[i]) bad++;
      check({tag, " stream mismatches"}, bad, 0);
      check({tag, " first val latency"}, first_val_cyc - req_cyc, 4);
      check({tag, " busy rise"}, first_busy_cyc - req_cyc, 1);
      check({tag, " done count"}, n_done, 1);
      check({tag, " done after last"}, done_cyc - last_xfer_cyc, 1);
      check({tag, " busy low at done"}, busy_done_bad, 0);
      check({tag, " err count"}, n_err, 0);
      check({tag, " fifo reads"}, n_rd, int'(i_len));
      check({tag, " hold while stalled"}, hold_bad, 0);
      check({tag, " empty fifo handling"}, gap_bad, 0);
   endtask

   typedef struct {
      logic [15:0] id, seq, len;
      logic [31:0] cks;
      int          rmode, gap_at, gap_len;
      bit          mid_req;
      logic [15:0] exp_c;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int k;
      logic [15:0] gc;
      rst = 1'b0; req = 1'b0; rdy = 1'b0; id = '0; seq = '0; len = '0; cks = '0;
      fifo_dat = '0; fifo_empty = 1'b1; gate = 1'b0;
      rd_pending = 1'b0; prev_stall = 1'b0; prev_dat = '0; prev_lst = 1'b0;
      clear_stats();

      tbl[0] = '{16'h1234, 16'h0001, 16'd4, 32'h0001FFFE, 0, -1, 0, 1'b0, 16'hEDCA};
      tbl[1] = '{16'h0001, 16'h0000, 16'd0, 32'h0000FFFF, 0, -1, 0, 1'b0, 16'hFFFE};
      tbl[2] = '{16'hFFFF, 16'h0000, 16'd2, 32'h00000000, 0,  1, 5, 1'b0, 16'h0000};
      tbl[3] = '{16'h5A5A, 16'h0102, 16'd3, 32'h00010000, 1, -1, 0, 1'b1, 16'hA4A2};
      tbl[4] = '{16'h8000, 16'h8000, 16'd5, 32'h00030000, 0, -1, 0, 1'b0, 16'hFFFB};
      tbl[5] = '{16'hFFFF, 16'hFFFF, 16'd1, 32'h0000FFFF, 2, -1, 0, 1'b0, 16'h0000};

      repeat (3) @(negedge clk);
      #1;
      check("reset outputs", {val, dat, lst, fifo_rd, busy, done, err}, 0);
      @(negedge clk);
      rst = 1'b1;
      cyc(1'b1, 1'b0, 1'b0);
      check("idle outputs", {val, dat, lst, fifo_rd, busy, done, err}, 0);

      // Directed table vectors
      foreach (tbl[i]) begin
         pl_q.delete();
         for (int b = 0; b < int'(tbl[i].len); b++) pl_q.push_back(8'(8'hAA + 8'h11 * b));
         run_pkt($sformatf("vec%0d", i), tbl[i].id, tbl[i].seq, tbl[i].len, tbl[i].cks,
                 tbl[i].rmode, tbl[i].gap_at, tbl[i].gap_len, tbl[i].mid_req);
         gc = (got.size() >= 4) ? {got[2][7:0], got[3][7:0]} : ~tbl[i].exp_c;
         check($sformatf("vec%0d checksum", i), gc, tbl[i].exp_c);
      end

      // Oversized request is rejected with a single err pulse
      clear_stats();
      issue_req(16'h0BAD, 16'h0002, 16'(MAX_PLD + 1), 32'h00000123);
      repeat (6) cyc(1'b1, 1'b0, 1'b0);
      check("reject err count", n_err, 1);
      check("reject err timing", err_cyc - req_cyc, 1);
      check("reject busy", busy_seen, 0);
      check("reject done", n_done, 0);
      check("reject val", first_val_cyc, -1);

      // Largest legal payload is accepted
      pl_q.delete();
      for (int b = 0; b < int'(MAX_PLD); b++) pl_q.push_back(8'($urandom));
      run_pkt("max len", 16'h4242, 16'h0007, 16'(MAX_PLD), 32'h00001234, 0, -1, 0, 1'b0);

      // Asynchronous reset in the middle of the payload
      clear_stats();
      pl_q.delete();
      for (int b = 0; b < 10; b++) pl_q.push_back(8'(b + 1));
      fifo_q = pl_q;
      issue_req(16'h7777, 16'h0003, 16'd10, 32'h00000000);
      k = 0;
      while (got.size() < 11 && k < 60) begin cyc(1'b1, 1'b0, 1'b0); k++; end
      check("pre-reset progress", got.size(), 11);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("async reset outputs", {val, dat, lst, fifo_rd, busy, done, err}, 0);
      @(negedge clk);
      rst = 1'b1;
      rd_pending = 1'b0; prev_stall = 1'b0;
      clear_stats();
      repeat (8) cyc(1'b1, 1'b0, 1'b0);
      check("post-reset done", n_done, 0);
      check("post-reset err", n_err, 0);
      check("post-reset val", first_val_cyc, -1);
      check("post-reset busy", busy_seen, 0);

      // FIFO never delivers payload
      clear_stats();
      pl_q = '{8'h11, 8'h22, 8'h33};
      fifo_q = pl_q;
      build_exp(16'h0102, 16'h0304, 32'h00000005);
      issue_req(16'h0102, 16'h0304, 16'd3, 32'h00000005);
`ifdef QNIGMA_ICMP_ECHO_TX_TIMEOUT_EN
      k = 0;
      while (n_err == 0 && k < 100) begin cyc(1'b1, 1'b0, 1'b1); k++; end
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check("timeout byte count", got.size(), 9);
      check("timeout byte", (got.size() >= 9) ? got[8] : 9'h0FF, 9'h100);
      check("timeout delay", (got_cyc.size() >= 9) ? got_cyc[8] - got_cyc[7] : -1, TO_TICKS + 1);
      check("timeout err timing", err_cyc - last_xfer_cyc, 1);
      check("timeout err count", n_err, 1);
      check("timeout done", n_done, 0);
      check("timeout reads", n_rd, 0);
      check("timeout busy after", busy, 0);
`else
      repeat (60) cyc(1'b1, 1'b0, 1'b1);
      check("stall bytes", got.size(), 8);
      check("stall busy", busy, 1);
      check("stall done", n_done, 0);
      check("stall err", n_err, 0);
      check("stall reads", n_rd, 0);
      check("stall val while empty", gap_bad, 0);
      k = 0;
      while (n_done == 0 && k < 30) begin cyc(1'b1, 1'b0, 1'b0); k++; end
      check("stall resume bytes", got.size(), 11);
      check("stall resume tail", (got.size() >= 11) ? got[10] : 9'h000, exp_q[10]);
      check("stall resume done", n_done, 1);
`endif
      fifo_q.delete();
      rd_pending = 1'b0;
      repeat (3) cyc(1'b1, 1'b0, 1'b0);

      // Randomised packets against the reference model
      for (int p = 0; p < 25; p++) begin
         int l;
         l = int'($urandom_range(0, 24));
         pl_q.delete();
         for (int b = 0; b < l; b++) pl_q.push_back(8'($urandom));
         run_pkt($sformatf("rand%0d", p), 16'($urandom), 16'($urandom), 16'(l),
                 $urandom & 32'h7FFF_FFFF, 2, -1, 0, (p % 5) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
